keypad_4x4_scan: RTL and testbench
==================================

# keypad_4x4_scan

Scanning reader for a 4x4 matrix keypad: drives one column at a time, samples the four row lines, debounces a detected press, and emits a single-cycle key event with a 4-bit key code. It is the input-side counterpart of the multiplexed FND display driver. Its `key_valid`/`key_code` outputs feed timer, counter and UI blocks in place of discrete `button_cntr` instances.

## Interface
- `SCAN_TICKS`, default 100_000: clocks each column is driven, which is 1 ms at 100 MHz; minimum 4.
- `DEBOUNCE_TICKS`, default 2_000_000: consecutive stable clocks required to accept a press or a release, which is 20 ms; minimum 2.
- `REPEAT_DELAY`, default 50_000_000: clocks held before the first auto-repeat; used only with the repeat macro.
- `REPEAT_PERIOD`, default 10_000_000: clocks between auto-repeats; used only with the repeat macro.
- `clk`  in  1  system clock; the block has one clock only.
- `reset_p`  in  1  synchronous, active-high reset.
- `row`  in  4  asynchronous row lines, active-high, pulled down externally.
- `col`  out  4  one-hot column drive, active-high.
- `key_code`  out  4  last accepted key, equal to row_idx*4 + col_idx.
- `key_valid`  out  1  one-cycle pulse when a key is accepted.
- `key_held`  out  1  high while the accepted key remains pressed.

## Operation
- `row` passes through a 2-flop synchronizer. All decisions use the synchronized value `row_s`.
- **Reset values:** `col`=4'b0001, `key_code`=0, `key_valid`=0, `key_held`=0, FSM in SCAN, all counters at 0.
- **SCAN:**
  - `col` rotates left every SCAN_TICKS clocks: 0001 → 0010 → 0100 → 1000 → 0001.
  - `row_s` is sampled only in the last clock of each column window, so the line has settled and passed through the synchronizer.
  - If the sample is nonzero, capture `col_idx`, and capture `row_idx` as the lowest-index set bit. Freeze `col` and enter DEBOUNCE.
- **DEBOUNCE:**
  - Each clock where `row_s[row_idx]`=1 increments the counter.
  - Any clock where it is 0 returns the FSM to SCAN. Scanning resumes at the next column with no event.
  - When the counter reaches DEBOUNCE_TICKS: `key_valid`=1 for one clock, `key_code` is loaded in the same clock, `key_held`=1, and the FSM enters PRESSED.
- **PRESSED:** `col` stays frozen. When `row_s`=0 for the whole frozen column, enter RELEASE.
- **RELEASE:**
  - Count consecutive clocks with `row_s`==0. Any nonzero `row_s` returns the FSM to PRESSED and clears the counter.
  - When the count reaches DEBOUNCE_TICKS: `key_held`=0, the FSM enters SCAN, and scanning resumes at the next column.
- **Multiple keys:**
  - Several rows set in one column: the lowest row wins.
  - Additional keys pressed while in PRESSED are ignored (no rollover).
  - `key_code` holds its value until the next accepted key; it is not cleared on release.
- **Reset mid-operation:** takes effect on the next clock from any state. A pending event is dropped and no `key_valid` is produced.

## Timing
- Latency from a row edge to `row_s`: 2 clocks.
- Latency from sampling a press to `key_valid`: DEBOUNCE_TICKS+1 clocks after the DEBOUNCE entry clock.
- `key_valid` is never asserted in two consecutive clocks.
- Repeat mode is the only path that can produce more than one pulse per physical press.
- `col` never changes while the FSM is in DEBOUNCE, PRESSED or RELEASE.
- Worst-case detection delay is 4*SCAN_TICKS + 2 clocks.

## Configuration
- **`KEYPAD_REPEAT_EN` defined:**
  - In PRESSED, a repeat counter runs.
  - First extra `key_valid` pulse after REPEAT_DELAY clocks, then one pulse every REPEAT_PERIOD clocks, each with the same `key_code`.
  - The counter clears on leaving PRESSED.
- **`KEYPAD_REPEAT_EN` undefined:**
  - The repeat counter is not present.
  - Exactly one `key_valid` per accepted press.
  - REPEAT_DELAY and REPEAT_PERIOD are unused.

## Structure
- **Shared package:** FSM state encoding (SCAN, DEBOUNCE, PRESSED, RELEASE) and the key-code width constant (4). Display and UI blocks import the same package.
- **Sub-module `sync_2ff`:** a 4-bit, parameterized-width synchronizer. This is the only sub-module; the FSM and counters stay in the top module.

## Test plan
Benches use SCAN_TICKS=8 and DEBOUNCE_TICKS=16.
- **Reset:** assert `reset_p` 3 clocks → `col`=0001, `key_valid`=0, `key_held`=0, `key_code`=0.
- **Clean press:** hold `row[2]` whenever `col[1]` is driven, for 40 clocks → exactly one `key_valid` pulse with `key_code`=9. Release → `key_held` falls 16 clocks after `row_s`=0 and scanning resumes at `col`=0100.
- **Bounce:** toggle `row[0]` on `col[3]` every 5 clocks for 50 clocks, then hold it stable → single pulse, `key_code`=3, only after 16 stable clocks.
- **Two keys:** `row[1]` and `row[3]` both high on `col[0]` → `key_code`=4. A second key pressed while the first is held produces no pulse.
- **Reset mid-DEBOUNCE:** after 10 stable clocks, assert `reset_p` → no `key_valid`, `col`=0001.
- **With `KEYPAD_REPEAT_EN`**, REPEAT_DELAY=32, REPEAT_PERIOD=8: hold key 5 for 60 clocks after acceptance → pulses at +0, +32, +40, +48, +56, all with `key_code`=5.

Source files
------------

// File: rtl/keypad_4x4_scan_pkg.sv
// Shared definitions for the keypad scanner and the display/UI blocks that consume key codes.
package keypad_4x4_scan_pkg;

    localparam int KEY_W = 4;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_PRESSED,
        ST_RELEASE
    } kp_state_t;

    // Lowest set bit wins when several rows are active in one column.
    function automatic logic [1:0] lowest_bit(input logic [3:0] v);
        lowest_bit = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (v[i]) lowest_bit = 2'(i);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        onehot_idx = 2'd0;
        for (int i = 0; i < 4; i++)
            if (v[i]) onehot_idx = 2'(i);
    endfunction

endpackage

// File: rtl/keypad_4x4_scan_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
module sync_2ff #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset_p) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_4x4_scan.sv
// 4x4 matrix keypad scanner with press/release debounce and one-cycle key events.
// Define KEYPAD_REPEAT_EN to enable auto-repeat while a key is held.
module keypad_4x4_scan
    import keypad_4x4_scan_pkg::*;
#(
    parameter int SCAN_TICKS     = 100_000,
    parameter int DEBOUNCE_TICKS = 2_000_000,
    parameter int REPEAT_DELAY   = 50_000_000,
    parameter int REPEAT_PERIOD  = 10_000_000
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [3:0]       row,
    output logic [3:0]       col,
    output logic [KEY_W-1:0] key_code,
    output logic             key_valid,
    output logic             key_held
);

    localparam int SCW = $clog2(SCAN_TICKS);
    localparam int DBW = $clog2(DEBOUNCE_TICKS + 1);
    localparam logic [SCW-1:0] SCAN_LAST = SCW'(SCAN_TICKS - 1);
    localparam logic [DBW-1:0] DEB_DONE  = DBW'(DEBOUNCE_TICKS);
    localparam logic [DBW-1:0] REL_LAST  = DBW'(DEBOUNCE_TICKS - 1);

    kp_state_t      state;
    logic [3:0]     row_s;
    logic [SCW-1:0] scan_cnt;
    logic [DBW-1:0] deb_cnt;
    logic [1:0]     row_idx;
    logic [1:0]     col_idx;
    logic           rep_fire;

    sync_2ff #(.WIDTH(4)) u_sync (
        .clk     (clk),
        .reset_p (reset_p),
        .d       (row),
        .q       (row_s)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam int RPW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RPW-1:0] REP_LAST   = RPW'(REPEAT_DELAY - 1);
    localparam logic [RPW-1:0] REP_RELOAD = RPW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RPW-1:0] rep_cnt;

    assign rep_fire = (state == ST_PRESSED) && (row_s != 4'b0) && (rep_cnt == REP_LAST);

    // Reloading to DELAY-PERIOD makes every later repeat land PERIOD clocks apart.
    always_ff @(posedge clk) begin
        if (reset_p || state != ST_PRESSED || row_s == 4'b0)
            rep_cnt <= '0;
        else if (rep_fire)
            rep_cnt <= REP_RELOAD;
        else
            rep_cnt <= rep_cnt + RPW'(1);
    end
`else
    assign rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset_p) begin
            state     <= ST_SCAN;
            col       <= 4'b0001;
            scan_cnt  <= '0;
            deb_cnt   <= '0;
            row_idx   <= '0;
            col_idx   <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            case (state)
                ST_SCAN: begin
                    // Sample only at the end of the window so the column has settled.
                    if (scan_cnt == SCAN_LAST) begin
                        scan_cnt <= '0;
                        if (row_s != 4'b0) begin
                            row_idx <= lowest_bit(row_s);
                            col_idx <= onehot_idx(col);
                            deb_cnt <= '0;
                            state   <= ST_DEBOUNCE;
                        end else begin
                            col <= {col[2:0], col[3]};
                        end
                    end else begin
                        scan_cnt <= scan_cnt + SCW'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (!row_s[row_idx]) begin
                        state <= ST_SCAN;
                        col   <= {col[2:0], col[3]};
                    end else if (deb_cnt == DEB_DONE) begin
                        key_valid <= 1'b1;
                        key_code  <= {row_idx, col_idx};
                        key_held  <= 1'b1;
                        state     <= ST_PRESSED;
                    end else begin
                        deb_cnt <= deb_cnt + DBW'(1);
                    end
                end
                ST_PRESSED: begin
                    // The clock that first sees an all-zero column counts toward release.
                    if (row_s == 4'b0) begin
                        state   <= ST_RELEASE;
                        deb_cnt <= DBW'(1);
                    end else if (rep_fire) begin
                        key_valid <= 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (row_s != 4'b0) begin
                        state   <= ST_PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == REL_LAST) begin
                        key_held <= 1'b0;
                        state    <= ST_SCAN;
                        col      <= {col[2:0], col[3]};
                    end else begin
                        deb_cnt <= deb_cnt + DBW'(1);
                    end
                end
                default: state <= ST_SCAN;
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_4x4_scan.sv
// Scoreboard bench for keypad_4x4_scan: a physical keypad model drives the rows, a monitor checks events.
module tb_keypad_4x4_scan;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [15:0] keys = '0;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int exp_q[$];
    int pulse_cyc[$];
    logic prev_kv = 1'b0;

    keypad_4x4_scan #(
        .SCAN_TICKS     (8),
        .DEBOUNCE_TICKS (16),
        .REPEAT_DELAY   (32),
        .REPEAT_PERIOD  (8)
    ) dut (
        .clk       (clk),
        .reset_p   (reset_p),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // A closed switch connects its column drive to its row line.
    always_comb begin
        row = 4'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4 + c] && col[c]) row[r] = 1'b1;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        int e;
        if (!reset_p && key_valid) begin
            chk("no_back_to_back", int'(prev_kv), 0);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_pulse: got key_code %0d, expected no event (cycle %0d)", key_code, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("key_code", int'(key_code), e);
                chk("held_with_valid", int'(key_held), 1);
            end
            pulse_cyc.push_back(cyc);
        end
        prev_kv = key_valid;
    end

    task automatic wait_pulse(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (key_valid) return;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s_timeout: got no key_valid, expected one within 100 clocks", name);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int t0;
        int c;
        int e;
        int nb;
        logic [3:0]  m;
        logic [15:0] pat;

        // Reset
        reset_p = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_col", int'(col), 1);
        chk("reset_valid", int'(key_valid), 0);
        chk("reset_held", int'(key_held), 0);
        chk("reset_code", int'(key_code), 0);

        // Clean press of row 2 / column 1, then release with exact timing
        reset_p = 1'b0;
        t0 = cyc;
        exp_q.push_back(9);
        keys[9] = 1'b1;
        wait_pulse("clean");
        while (cyc - t0 < 40) @(negedge clk);
        keys = '0;
        repeat (17) @(negedge clk);
        chk("release_held_before", int'(key_held), 1);
        @(negedge clk);
        chk("release_held_after", int'(key_held), 0);
        chk("release_col_next", int'(col), 4);
        repeat (10) @(negedge clk);

        // Bounce on row 0 / column 3
        for (int i = 0; i < 10; i++) begin
            keys[3] = ~keys[3];
            repeat (5) @(negedge clk);
        end
        keys[3] = 1'b1;
        t0 = cyc;
        exp_q.push_back(3);
        wait_pulse("bounce");
        chk("bounce_min_latency", int'((cyc - t0) >= 18), 1);
        chk("bounce_max_latency", int'((cyc - t0) <= 53), 1);
        keys = '0;
        repeat (30) @(negedge clk);

        // Two rows in one column, then a rollover attempt
        keys[4]  = 1'b1;
        keys[12] = 1'b1;
        exp_q.push_back(4);
        wait_pulse("two_keys");
        keys[6] = 1'b1;
        repeat (25) @(negedge clk);
        chk("two_keys_held", int'(key_held), 1);
        keys = '0;
        repeat (30) @(negedge clk);
        chk("two_keys_released", int'(key_held), 0);
        chk("code_kept_after_release", int'(key_code), 4);

        // Reset while debouncing: 8 clocks to sample, then 10 stable clocks
        reset_p = 1'b1;
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        keys[0] = 1'b1;
        repeat (18) @(negedge clk);
        reset_p = 1'b1;
        repeat (2) @(negedge clk);
        keys = '0;
        chk("midreset_col", int'(col), 1);
        chk("midreset_valid", int'(key_valid), 0);
        chk("midreset_held", int'(key_held), 0);
        chk("midreset_code", int'(key_code), 0);
        reset_p = 1'b0;
        repeat (40) @(negedge clk);

`ifdef KEYPAD_REPEAT_EN
        // Auto-repeat on row 1 / column 1
        pulse_cyc.delete();
        for (int i = 0; i < 5; i++) exp_q.push_back(5);
        keys[5] = 1'b1;
        wait_pulse("repeat");
        t0 = cyc;
        while (cyc - t0 < 60) @(negedge clk);
        keys = '0;
        repeat (30) @(negedge clk);
        chk("repeat_count", pulse_cyc.size(), 5);
        if (pulse_cyc.size() == 5)
            for (int k = 1; k < 5; k++)
                chk("repeat_offset", pulse_cyc[k] - pulse_cyc[0], 24 + 8*k);
`endif

        // Randomized presses, one column at a time, with optional bounce
        for (int it = 0; it < 12; it++) begin
            c = $urandom_range(0, 3);
            m = 4'($urandom_range(1, 15));
            pat = '0;
            e = -1;
            for (int r = 0; r < 4; r++) begin
                if (m[r]) begin
                    pat[r*4 + c] = 1'b1;
                    if (e < 0) e = r*4 + c;
                end
            end
            nb = $urandom_range(0, 2);
            for (int b = 0; b < nb; b++) begin
                keys = pat;
                repeat ($urandom_range(1, 10)) @(negedge clk);
                keys = '0;
                repeat ($urandom_range(1, 10)) @(negedge clk);
            end
            keys = pat;
            exp_q.push_back(e);
            wait_pulse("random");
            repeat ($urandom_range(0, 20)) @(negedge clk);
            keys = '0;
            repeat (30) @(negedge clk);
            chk("random_released", int'(key_held), 0);
            chk("random_code_kept", int'(key_code), e);
        end

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
